// File: rtl/crc_framer_if.sv
// crc_framer_if -- byte-stream bundle between an upstream source, the
// CRC framer and its downstream sink.
//
// Build option: CRC_FRAMER_ERR_EN adds the errout protocol-error pulse.
//
// Signals
//   pushin    upstream byte valid
//   datain    upstream payload byte
//   startin   datain is the first byte of a frame
//   endin     datain is the last byte of a frame
//   readyout  framer accepts pushin this cycle
//   pushout   downstream byte valid
//   dataout   downstream byte (payload, then FCS least significant first)
//   startout  first byte of the framed output
//   endout    last byte of the framed output (last FCS byte)
//   errout    one-cycle protocol-error pulse (CRC_FRAMER_ERR_EN only)
//
// Modports
//   master  upstream/downstream side (drives the inputs of the framer)
//   slave   the framer itself
interface crc_framer_if;
    logic       pushin;
    logic [7:0] datain;
    logic       startin;
    logic       endin;
    logic       readyout;
    logic       pushout;
    logic [7:0] dataout;
    logic       startout;
    logic       endout;
`ifdef CRC_FRAMER_ERR_EN
    logic       errout;

    modport master (
        output pushin, datain, startin, endin,
        input  readyout, pushout, dataout, startout, endout, errout
    );

    modport slave (
        input  pushin, datain, startin, endin,
        output readyout, pushout, dataout, startout, endout, errout
    );
`else
    modport master (
        output pushin, datain, startin, endin,
        input  readyout, pushout, dataout, startout, endout
    );

    modport slave (
        input  pushin, datain, startin, endin,
        output readyout, pushout, dataout, startout, endout
    );
`endif
endinterface

// File: rtl/crc_framer.sv
// crc_framer -- appends a CRC-32 FCS (reflected poly 0xEDB88320, init
// 0xFFFFFFFF, final inversion) to each byte frame passing through.
//
// Build option: CRC_FRAMER_ERR_EN adds bus.errout, a one-cycle pulse after
// any edge where a byte is dropped in IDLE, a frame is restarted in DATA,
// or pushin is asserted while readyout is low.
//
// Ports
//   clk  rising-edge clock, sole clock domain
//   rst  synchronous reset, active-low
//   bus  crc_framer_if.slave byte-stream bundle (see crc_framer_if.sv)
//
// Payload bytes come out two register stages after the input edge, so a
// byte accepted at edge N appears after edge N+1. FCS bytes are produced by
// the APPEND state into the same pipeline, landing right behind the last
// payload byte, and readyout is low for the four APPEND cycles.
module crc_framer (
    input  logic        clk,
    input  logic        rst,
    crc_framer_if.slave bus
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] crc, crc_nxt;

    logic        vld_p0, sop_p0, eop_p0;
    logic [7:0]  data_p0;
    logic        vld_p1, sop_p1, eop_p1;
    logic [7:0]  data_p1;
    logic        vld_p2, sop_p2, eop_p2;
    logic [7:0]  data_p2;

    // Bit-serial form of the byte table update
    // crc = (crc >> 8) ^ T[(crc ^ byte) & 0xFF]; the two are identical
    // because the update is linear over GF(2).
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in,
                                             input logic [7:0]  b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] c,
                                            input logic [1:0]  k);
        logic [31:0] fcs;
        fcs = ~c;
        return fcs[{k, 3'b000} +: 8];
    endfunction

    assign bus.readyout = (state != APPEND);

    // Stage p0: FSM decides what enters the output pipeline this cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        vld_p0    = 1'b0;
        sop_p0    = 1'b0;
        eop_p0    = 1'b0;
        data_p0   = 8'h00;
        case (state)
            IDLE: begin
                // Bytes without startin are dropped here.
                if (bus.pushin && bus.startin) begin
                    crc_nxt   = crc_byte(CRC_INIT, bus.datain);
                    vld_p0    = 1'b1;
                    sop_p0    = 1'b1;
                    data_p0   = bus.datain;
                    cnt_nxt   = 2'd0;
                    state_nxt = bus.endin ? APPEND : DATA;
                end
            end
            DATA: begin
                if (bus.pushin) begin
                    vld_p0  = 1'b1;
                    data_p0 = bus.datain;
                    if (bus.startin) begin
                        // Restart: old frame abandoned without an FCS.
                        crc_nxt = crc_byte(CRC_INIT, bus.datain);
                        sop_p0  = 1'b1;
                    end else begin
                        crc_nxt = crc_byte(crc, bus.datain);
                    end
                    if (bus.endin) begin
                        cnt_nxt   = 2'd0;
                        state_nxt = APPEND;
                    end
                end
            end
            APPEND: begin
                vld_p0  = 1'b1;
                data_p0 = fcs_byte(crc, cnt);
                if (cnt == 2'd3) begin
                    eop_p0    = 1'b1;
                    cnt_nxt   = 2'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Stage p1/p2: two-deep output pipeline, cleared by reset so an
    // aborted frame emits nothing further.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            crc     <= CRC_INIT;
            vld_p1  <= 1'b0;
            sop_p1  <= 1'b0;
            eop_p1  <= 1'b0;
            data_p1 <= 8'h00;
            vld_p2  <= 1'b0;
            sop_p2  <= 1'b0;
            eop_p2  <= 1'b0;
            data_p2 <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            crc     <= crc_nxt;
            vld_p1  <= vld_p0;
            sop_p1  <= sop_p0;
            eop_p1  <= eop_p0;
            data_p1 <= data_p0;
            vld_p2  <= vld_p1;
            sop_p2  <= sop_p1;
            eop_p2  <= eop_p1;
            data_p2 <= data_p1;
        end
    end

    assign bus.pushout  = vld_p2;
    assign bus.startout = sop_p2;
    assign bus.endout   = eop_p2;
    assign bus.dataout  = data_p2;

`ifdef CRC_FRAMER_ERR_EN
    logic err_p0;
    logic err_p1;

    always_comb begin
        err_p0 = 1'b0;
        if (bus.pushin) begin
            if (!bus.readyout)
                err_p0 = 1'b1;
            else if (state == IDLE && !bus.startin)
                err_p0 = 1'b1;
            else if (state == DATA && bus.startin)
                err_p0 = 1'b1;
        end
    end

    // Stage p1: error pulse registered at the offending edge
    always_ff @(posedge clk) begin
        if (!rst)
            err_p1 <= 1'b0;
        else
            err_p1 <= err_p0;
    end

    assign bus.errout = err_p1;
`endif

endmodule

// File: tb/tb_crc_framer.sv
module tb_crc_framer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mon_en = 1'b0;

    crc_framer_if bus ();

    crc_framer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output bytes: {startout, endout, dataout}
    logic [9:0] exp_q[$];

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                            8'h36, 8'h37, 8'h38, 8'h39};

    localparam logic [31:0] FCS_123456789 = 32'hCBF43926;
    localparam logic [31:0] FCS_ZERO_BYTE = 32'hD202EF8D;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_byte(input logic [7:0] d, input logic s, input logic e);
        exp_q.push_back({s, e, d});
    endtask

    task automatic exp_fcs(input logic [31:0] fcs);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, (k == 3), fcs[8*k +: 8]});
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s, input logic e);
        bus.pushin  = 1'b1;
        bus.datain  = d;
        bus.startin = s;
        bus.endin   = e;
        @(posedge clk);
        #1;
        bus.pushin  = 1'b0;
        bus.datain  = 8'h00;
        bus.startin = 1'b0;
        bus.endin   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_msg(input bit gaps);
        for (int i = 0; i < 9; i++) begin
            exp_byte(msg[i], (i == 0), 1'b0);
            push(msg[i], (i == 0), (i == 8));
            if (gaps && i < 8) idle(1);
        end
    endtask

    // Monitor: pops one expected byte per pushout, checks idle zeros otherwise
    always @(negedge clk) begin
        logic [9:0] e;
        if (mon_en) begin
            if (bus.pushout === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h (sop=%0b eop=%0b), required no output",
                             bus.dataout, bus.startout, bus.endout);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'({bus.startout, bus.endout, bus.dataout}), 32'(e));
                end
            end else begin
                check("idle_zero", 32'({bus.pushout, bus.startout, bus.endout, bus.dataout}), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;
        bus.pushin  = 1'b0;
        bus.datain  = 8'h00;
        bus.startin = 1'b0;
        bus.endin   = 1'b0;

        // Reset state
        rst = 1'b0;
        idle(3);
        check("rst_pushout",  32'(bus.pushout),  32'h0);
        check("rst_dataout",  32'(bus.dataout),  32'h0);
        check("rst_startout", 32'(bus.startout), 32'h0);
        check("rst_endout",   32'(bus.endout),   32'h0);
        check("rst_readyout", 32'(bus.readyout), 32'h1);
`ifdef CRC_FRAMER_ERR_EN
        check("rst_errout",   32'(bus.errout),   32'h0);
`endif
        mon_en = 1'b1;
        rst = 1'b1;
        idle(2);

        // "123456789" back-to-back, readyout low for 4 cycles
        send_msg(1'b0);
        exp_fcs(FCS_123456789);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.readyout !== 1'b1) lows++;
            idle(1);
        end
        check("ready_low_cycles", 32'(lows), 32'd4);
        idle(3);

        // Single byte 0x00 with startin&endin: 5 consecutive output cycles
        exp_byte(8'h00, 1'b1, 1'b0);
        exp_fcs(FCS_ZERO_BYTE);
        push(8'h00, 1'b1, 1'b1);
        check("single_lat_pre", 32'(bus.pushout), 32'h0);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check("single_consec", 32'(bus.pushout), 32'h1);
        end
        idle(1);
        check("single_post", 32'(bus.pushout), 32'h0);
        idle(2);

        // Gaps between every byte
        send_msg(1'b1);
        exp_fcs(FCS_123456789);
        idle(8);

        // pushin held during APPEND with 0xAA, then drop in IDLE
        send_msg(1'b0);
        exp_fcs(FCS_123456789);
        push(8'hAA, 1'b0, 1'b0);
`ifdef CRC_FRAMER_ERR_EN
        check("err_append", 32'(bus.errout), 32'h1);
`endif
        push(8'hAA, 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        idle(3);
        check("ready_after_append", 32'(bus.readyout), 32'h1);
        push(8'h55, 1'b0, 1'b0);
`ifdef CRC_FRAMER_ERR_EN
        check("err_drop", 32'(bus.errout), 32'h1);
`endif
        idle(1);
`ifdef CRC_FRAMER_ERR_EN
        check("err_one_cycle", 32'(bus.errout), 32'h0);
`endif
        send_msg(1'b0);
        exp_fcs(FCS_123456789);
        idle(8);

        // Reset after the second FCS byte aborts the frame
        send_msg(1'b0);
        exp_byte(8'h26, 1'b0, 1'b0);
        exp_byte(8'h39, 1'b0, 1'b0);
        idle(3);
        rst = 1'b0;
        idle(1);
        check("midrst_pushout",  32'(bus.pushout),  32'h0);
        check("midrst_dataout",  32'(bus.dataout),  32'h0);
        check("midrst_startout", 32'(bus.startout), 32'h0);
        check("midrst_endout",   32'(bus.endout),   32'h0);
        check("midrst_readyout", 32'(bus.readyout), 32'h1);
        rst = 1'b1;
        idle(4);
        check("midrst_queue_empty", 32'(exp_q.size()), 32'h0);
        send_msg(1'b0);
        exp_fcs(FCS_123456789);
        idle(8);

        // Restart after 3 bytes: abandoned frame gets no FCS
        exp_byte(8'h41, 1'b1, 1'b0);
        push(8'h41, 1'b1, 1'b0);
        exp_byte(8'h42, 1'b0, 1'b0);
        push(8'h42, 1'b0, 1'b0);
        exp_byte(8'h43, 1'b0, 1'b0);
        push(8'h43, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            exp_byte(msg[i], (i == 0), 1'b0);
            push(msg[i], (i == 0), (i == 8));
`ifdef CRC_FRAMER_ERR_EN
            if (i == 0) check("err_restart", 32'(bus.errout), 32'h1);
`endif
        end
        exp_fcs(FCS_123456789);
        idle(10);

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
